// File: rtl/game_sequencer.sv
// Light-cycle stage controller: frame ticks, key decode, step handshake, scoring.
// Optional pause feature enabled by defining GAME_PAUSE_EN.
module game_sequencer #(
  parameter int unsigned TICK_FRAMES  = 4,
  parameter int unsigned COUNT_FRAMES = 180,
  parameter int unsigned CRASH_FRAMES = 120,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       vSync,
  input  logic [7:0] keyCode,
  input  logic       keyStrobe,
  input  logic       clearDone,
  input  logic       stepDone,
  input  logic       crashA,
  input  logic       crashB,
  output logic [2:0] stage,
  output logic       clearArena,
  output logic       stepEn,
  output logic [1:0] dirA,
  output logic [1:0] dirB,
  output logic [3:0] scoreA,
  output logic [3:0] scoreB,
  output logic [1:0] winner
);

  localparam int unsigned FCNT_W = 12;
  localparam int unsigned TCNT_W = 8;
  localparam logic [FCNT_W-1:0] COUNT_LAST = FCNT_W'(COUNT_FRAMES - 1);
  localparam logic [FCNT_W-1:0] CRASH_LAST = FCNT_W'(CRASH_FRAMES - 1);
  localparam logic [TCNT_W-1:0] TICK_LAST  = TCNT_W'(TICK_FRAMES - 1);
  localparam logic [3:0]        WIN_VAL    = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_COUNT = 3'd2,
    ST_PLAY  = 3'd3,
    ST_CRASH = 3'd4,
    ST_OVER  = 3'd5,
    ST_PAUSE = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic               vsync_q, tick_q;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [TCNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic               outstanding_q, outstanding_d;
  logic               step_en_q, step_en_d;
  logic               clear_arena_q, clear_arena_d;
  logic [1:0]         dir_a_q, dir_a_d, dir_b_q, dir_b_d;
  logic [1:0]         pdir_a_q, pdir_a_d, pdir_b_q, pdir_b_d;
  logic [3:0]         score_a_q, score_a_d, score_b_q, score_b_d;
  logic [1:0]         winner_q, winner_d;

  logic       key_start_c, key_abort_c, steer_ok_c;
  logic       steer_a_vld_c, steer_b_vld_c;
  logic [1:0] steer_a_dir_c, steer_b_dir_c;
  logic       done_c, crash_any_c, win_c;

  assign key_start_c = keyStrobe && (keyCode == 8'h29);
  assign key_abort_c = keyStrobe && (keyCode == 8'h76);
  // Only steps we actually issued are honoured; abort forgets the outstanding one.
  assign done_c      = stepDone && outstanding_q;
  assign crash_any_c = crashA || crashB;
  assign win_c       = (score_a_q == WIN_VAL) || (score_b_q == WIN_VAL);

`ifdef GAME_PAUSE_EN
  logic key_pause_c;
  assign key_pause_c = keyStrobe && (keyCode == 8'h4D);
  assign steer_ok_c  = (state_q == ST_COUNT) || (state_q == ST_PLAY) || (state_q == ST_PAUSE);
`else
  assign steer_ok_c  = (state_q == ST_COUNT) || (state_q == ST_PLAY);
`endif

  always_comb begin
    steer_a_vld_c = 1'b0;
    steer_b_vld_c = 1'b0;
    steer_a_dir_c = 2'b00;
    steer_b_dir_c = 2'b00;
    if (keyStrobe) begin
      case (keyCode)
        8'h1D: begin steer_a_vld_c = 1'b1; steer_a_dir_c = 2'b00; end
        8'h23: begin steer_a_vld_c = 1'b1; steer_a_dir_c = 2'b01; end
        8'h1B: begin steer_a_vld_c = 1'b1; steer_a_dir_c = 2'b10; end
        8'h1C: begin steer_a_vld_c = 1'b1; steer_a_dir_c = 2'b11; end
        8'h75: begin steer_b_vld_c = 1'b1; steer_b_dir_c = 2'b00; end
        8'h74: begin steer_b_vld_c = 1'b1; steer_b_dir_c = 2'b01; end
        8'h72: begin steer_b_vld_c = 1'b1; steer_b_dir_c = 2'b10; end
        8'h6B: begin steer_b_vld_c = 1'b1; steer_b_dir_c = 2'b11; end
        default: ;
      endcase
    end
  end

  // State register plus all registered datapath/outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= ST_IDLE;
      vsync_q       <= 1'b1;
      tick_q        <= 1'b0;
      frame_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      outstanding_q <= 1'b0;
      step_en_q     <= 1'b0;
      clear_arena_q <= 1'b0;
      dir_a_q       <= 2'b01;
      dir_b_q       <= 2'b11;
      pdir_a_q      <= 2'b01;
      pdir_b_q      <= 2'b11;
      score_a_q     <= 4'd0;
      score_b_q     <= 4'd0;
      winner_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vSync;
      tick_q        <= vsync_q & ~vSync;
      frame_cnt_q   <= frame_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      outstanding_q <= outstanding_d;
      step_en_q     <= step_en_d;
      clear_arena_q <= clear_arena_d;
      dir_a_q       <= dir_a_d;
      dir_b_q       <= dir_b_d;
      pdir_a_q      <= pdir_a_d;
      pdir_b_q      <= pdir_b_d;
      score_a_q     <= score_a_d;
      score_b_q     <= score_b_d;
      winner_q      <= winner_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (key_abort_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (key_start_c) state_d = ST_CLEAR;
        ST_CLEAR: if (clearDone) state_d = ST_COUNT;
        ST_COUNT: if (tick_q && (frame_cnt_q == COUNT_LAST)) state_d = ST_PLAY;
        ST_PLAY: begin
          if (done_c && crash_any_c) state_d = ST_CRASH;
`ifdef GAME_PAUSE_EN
          else if (key_pause_c) state_d = ST_PAUSE;
`endif
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSE: begin
          if (done_c && crash_any_c) state_d = ST_CRASH;
          else if (key_pause_c) state_d = ST_PLAY;
        end
`endif
        ST_CRASH: if (tick_q && (frame_cnt_q == CRASH_LAST)) state_d = win_c ? ST_OVER : ST_CLEAR;
        ST_OVER:  if (key_start_c) state_d = ST_CLEAR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    outstanding_d = outstanding_q;
    step_en_d     = 1'b0;
    clear_arena_d = 1'b0;
    dir_a_d       = dir_a_q;
    dir_b_d       = dir_b_q;
    pdir_a_d      = pdir_a_q;
    pdir_b_d      = pdir_b_q;
    score_a_d     = score_a_q;
    score_b_d     = score_b_q;
    winner_d      = winner_q;

    if (state_d != state_q) begin
      frame_cnt_d = '0;
      tick_cnt_d  = '0;
    end else if (tick_q && ((state_q == ST_COUNT) || (state_q == ST_CRASH))) begin
      frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
      clear_arena_d = 1'b1;
      dir_a_d       = 2'b01;
      pdir_a_d      = 2'b01;
      dir_b_d       = 2'b11;
      pdir_b_d      = 2'b11;
    end

    // Step completion is handled before a same-cycle tick can issue the next step
    if (done_c) begin
      outstanding_d = 1'b0;
      if (crashA && !crashB && (score_b_q != 4'd15)) score_b_d = score_b_q + 4'd1;
      if (crashB && !crashA && (score_a_q != 4'd15)) score_a_d = score_a_q + 4'd1;
    end

    if ((state_q == ST_PLAY) && (state_d == ST_PLAY) && tick_q) begin
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_d = '0;
        if (!outstanding_d) begin
          step_en_d     = 1'b1;
          outstanding_d = 1'b1;
          dir_a_d       = pdir_a_q;
          dir_b_d       = pdir_b_q;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + TCNT_W'(1);
      end
    end

    // A reversal against the committed heading is rejected outright
    if (steer_ok_c && steer_a_vld_c && (steer_a_dir_c != (dir_a_q ^ 2'b10))) pdir_a_d = steer_a_dir_c;
    if (steer_ok_c && steer_b_vld_c && (steer_b_dir_c != (dir_b_q ^ 2'b10))) pdir_b_d = steer_b_dir_c;

    if ((state_q == ST_CRASH) && (state_d == ST_OVER)) begin
      winner_d = (score_a_q == WIN_VAL) ? 2'b01 : 2'b10;
    end

    if ((state_q == ST_OVER) && (state_d == ST_CLEAR)) begin
      score_a_d = 4'd0;
      score_b_d = 4'd0;
      winner_d  = 2'b00;
    end

    if (key_abort_c) begin
      score_a_d     = 4'd0;
      score_b_d     = 4'd0;
      winner_d      = 2'b00;
      outstanding_d = 1'b0;
      step_en_d     = 1'b0;
    end
  end

  assign stage      = state_q;
  assign clearArena = clear_arena_q;
  assign stepEn     = step_en_q;
  assign dirA       = dir_a_q;
  assign dirB       = dir_b_q;
  assign scoreA     = score_a_q;
  assign scoreB     = score_b_q;
  assign winner     = winner_q;

endmodule
